// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_pkg : shared constants, FSM encoding and GF(2^8) helpers for AES decrypt |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_KW = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_FINAL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Entry 0x00 occupies the top byte; each line holds entries 0xR0..0xRF.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_inv_round : one combinational AES inverse-cipher round                   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_round_i,
  output logic [127:0] next_state_o
);

  logic [127:0] w_shift;
  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;

  // Block is column-major: byte 4*c+r sits at row r, column c; row r rotates right by r bytes.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 4 * c + r;
      localparam int SRC = 4 * ((c - r + 4) % 4) + r;
      assign w_shift[127 - 8*DST -: 8] = state_i[127 - 8*SRC -: 8];
      assign w_sub[127 - 8*DST -: 8]   = inv_sbox(w_shift[127 - 8*DST -: 8]);
    end
    assign w_mix[127 - 32*c -: 32] = inv_mix_col(w_ark[127 - 32*c -: 32]);
  end

  assign w_ark        = w_sub ^ round_key_i;
  assign next_state_o = last_round_i ? w_ark : w_mix;

endmodule
`default_nettype wire

// File: rtl/aes_dec_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_dec_round_ctrl : iterative AES decryptor, one round per clock            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int KW = AES_KW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [127:0]  data_in_i,
  input  logic [127:0]  round_key_i,
  output logic [KW-1:0] key_idx_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [127:0]  data_out_o
);

  localparam logic [KW-1:0] NR_K  = KW'(NR);
  localparam logic [KW-1:0] NR_M1 = KW'(NR - 1);
  localparam logic [KW-1:0] ONE_K = KW'(1);

  logic [2:0]    fsm_q, fsm_d;
  logic [127:0]  blk_q, blk_d;
  logic [KW-1:0] rnd_q, rnd_d;
  logic [127:0]  dout_q, dout_d;
  logic [127:0]  w_round;
  logic          w_last;

  assign w_last = (fsm_q == ST_FINAL);

  aes_inv_round u_round (
    .state_i      (blk_q),
    .round_key_i  (round_key_i),
    .last_round_i (w_last),
    .next_state_o (w_round)
  );

  always_comb begin
    fsm_d  = fsm_q;
    blk_d  = blk_q;
    rnd_d  = rnd_q;
    dout_d = dout_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          blk_d = data_in_i;
          rnd_d = NR_K;
          fsm_d = ST_INIT;
        end
      end
      ST_INIT: begin
        blk_d = blk_q ^ round_key_i;
        rnd_d = NR_M1;
        fsm_d = (NR > 1) ? ST_ROUND : ST_FINAL;
      end
      ST_ROUND: begin
        blk_d = w_round;
        // Saturate at zero so the counter cannot wrap into an out-of-range key index.
        if (rnd_q <= ONE_K) begin
          rnd_d = '0;
          fsm_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q - ONE_K;
        end
      end
      ST_FINAL: begin
        blk_d  = w_round;
        dout_d = w_round;
        rnd_d  = '0;
        fsm_d  = ST_DONE;
      end
      ST_DONE: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q  <= ST_IDLE;
      blk_q  <= '0;
      rnd_q  <= '0;
      dout_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      blk_q  <= blk_d;
      rnd_q  <= rnd_d;
      dout_q <= dout_d;
    end
  end

  always_comb begin
    key_idx_o = '0;
    case (fsm_q)
      ST_INIT:  key_idx_o = NR_K;
      ST_ROUND: key_idx_o = rnd_q;
      default:  key_idx_o = '0;
    endcase
  end

  assign busy_o     = (fsm_q == ST_INIT) || (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);
  assign done_o     = (fsm_q == ST_DONE);
  assign data_out_o = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_dec_round_ctrl : directed self-checking bench for aes_dec_round_ctrl  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_aes_dec_round_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] data_in;
  logic [127:0] round_key;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  logic [127:0] rk  [11];
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  int n_cmp;
  int n_err;

  assign round_key = (key_idx <= 4'd10) ? rk[key_idx] : 128'd0;

  aes_dec_round_ctrl #(.NR(10), .KW(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .data_in_i   (data_in),
    .round_key_i (round_key),
    .key_idx_o   (key_idx),
    .busy_o      (busy),
    .done_o      (done),
    .data_out_o  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field multiply by carry-less product followed by reduction modulo 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'd0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'd0, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
    return v[127 - 8*i -: 8];
  endfunction

  task automatic build_sbox;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] a;
      logic [7:0] inv;
      logic [7:0] s;
      a   = 8'(x);
      inv = 8'd0;
      if (a != 8'd0) begin
        inv = 8'd1;
        repeat (254) inv = gm(inv, a);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = a;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'd0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [7:0]   m [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] res;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 16; i++) m[i] = byte_of(ct, i) ^ byte_of(rk[10], i);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*((c + r) % 4) + r] = isb[m[4*c + r]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ byte_of(rk[rnd], i);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          logic [7:0] acc;
          acc = 8'd0;
          if (rnd > 0) begin
            for (int k = 0; k < 4; k++) acc = acc ^ gm(t[4*c + k], coef[(k - r + 4) % 4]);
          end else begin
            acc = t[4*c + r];
          end
          m[4*c + r] = acc;
        end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = m[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_pulse(input logic [127:0] ct);
    data_in = ct;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Entered at cycle 1 (first cycle after acceptance); returns on the cycle done is seen.
  task automatic wait_done(input int poke, input bit key_chk, input logic [127:0] hold_val,
                           output int dcyc, output int bcnt, output int early);
    int cyc;
    cyc   = 1;
    dcyc  = 0;
    bcnt  = 0;
    early = 0;
    while (cyc <= 40 && dcyc == 0) begin
      if (key_chk)
        chk($sformatf("keyidx_c%0d", cyc), 128'(key_idx), (cyc <= 10) ? 128'(11 - cyc) : 128'd0);
      if (busy) bcnt++;
      if (done) begin
        dcyc = cyc;
      end else begin
        if (data_out !== hold_val) early++;
        start = (cyc == poke);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, bc, ec, n;
    int dq[$];
    int g1, g2, first;
    logic [127:0] hexp [3];
    logic [127:0] exp_z;

    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b0;
    start   = 1'b0;
    data_in = 128'd0;
    build_sbox();
    expand_key(C1_KEY);
    #1 rst = 1'b1;

    @(negedge clk);
    chk("rst_keyidx", 128'(key_idx), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_dout", data_out, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 with key index trace
    start_pulse(C1_CT);
    wait_done(0, 1'b1, 128'd0, dc, bc, ec);
    chk("c1_done_cyc", 128'(dc), 128'd12);
    chk("c1_dout", data_out, C1_PT);
    chk("c1_busy_cycles", 128'(bc), 128'd11);
    chk("c1_dout_early", 128'(ec), 128'd0);
    chk("c1_busy_in_done", 128'(busy), 128'd0);
    @(negedge clk);
    chk("c1_done_width", 128'(done), 128'd0);

    // Start while busy is ignored
    start_pulse(C1_CT);
    wait_done(5, 1'b0, C1_PT, dc, bc, ec);
    chk("ign_done_cyc", 128'(dc), 128'd12);
    chk("ign_dout", data_out, C1_PT);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("ign_extra_done", 128'(n), 128'd0);

    // Reset mid-operation, then restart in the first idle cycle
    start_pulse(C1_CT);
    repeat (5) @(negedge clk);
    chk("rst6_busy_pre", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("rst6_keyidx", 128'(key_idx), 128'd0);
    chk("rst6_busy", 128'(busy), 128'd0);
    chk("rst6_done", 128'(done), 128'd0);
    chk("rst6_dout", data_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    start_pulse(C1_CT);
    wait_done(0, 1'b0, 128'd0, dc, bc, ec);
    chk("rst6_done_cyc", 128'(dc), 128'd12);
    chk("rst6_dout_new", data_out, C1_PT);
    chk("rst6_dout_early", 128'(ec), 128'd0);
    @(negedge clk);

    // Start held high: back-to-back operations with fresh DataIn each time
    hexp[0] = C1_PT;
    hexp[1] = ref_decrypt(CT2);
    hexp[2] = C1_PT;
    data_in = C1_CT;
    start   = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      if (done) begin
        if (dq.size() < 3) chk($sformatf("hold_dout%0d", dq.size()), data_out, hexp[dq.size()]);
        dq.push_back(k);
      end
      if (k == 1)  data_in = CT2;
      if (k == 14) data_in = C1_CT;
      if (k == 30) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    first = (dq.size() >= 1) ? dq[0] : -1;
    g1    = (dq.size() >= 2) ? dq[1] - dq[0] : -1;
    g2    = (dq.size() >= 3) ? dq[2] - dq[1] : -1;
    chk("hold_npulse", 128'(dq.size()), 128'd3);
    chk("hold_first", 128'(first), 128'd12);
    chk("hold_gap1", 128'(g1), 128'd13);
    chk("hold_gap2", 128'(g2), 128'd13);

    // All-zero key and block against the software model, then idle stability
    expand_key(128'd0);
    exp_z = ref_decrypt(128'd0);
    start_pulse(128'd0);
    wait_done(0, 1'b0, C1_PT, dc, bc, ec);
    chk("zero_done_cyc", 128'(dc), 128'd12);
    chk("zero_dout", data_out, exp_z);
    chk("zero_dout_early", 128'(ec), 128'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      if (data_out !== exp_z || done) n++;
    end
    chk("zero_idle_stable", 128'(n), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
